// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_responder slice: FSM state encoding,
// word geometry, wait-counter width and the captured request payload.
package mem_resp_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // Request fields latched at acceptance
   typedef struct packed {
      logic                  we;
      logic [DATA_W-1:0]     wdata;
      logic [WORD_BYTES-1:0] byte_en;
   } req_t;

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x 32 synchronous storage with per-byte write enables and a
// registered, enable-gated read port. Contents are not reset; only the
// read-data register is.
//   clk, rst_n      : clock, async active-low reset (read register only)
//   rd_en, rd_idx   : load rdata from word rd_idx at the next edge
//   wr_en, wr_idx   : write word wr_idx at the next edge
//   wdata, byte_en  : write data and lane enables
//   rdata           : registered read data, holds between reads
module mem_resp_array
   import mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_idx,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_idx,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [WORD_BYTES-1:0] byte_en,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // Byte-lane writes
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (byte_en[i]) begin
               mem_q[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Read register updates only when a read response is being launched
   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = mem_q[rd_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Handshaked data-memory responder: accepts one read or byte-enabled write
// at a time, inserts WAIT_CYCLES wait states, then completes with a
// single-cycle Ack (plus Err for rejected requests).
// Optional: define MEMRESP_ERR_CHECK_EN to reject misaligned or
// out-of-range addresses; otherwise the word index wraps modulo 2^AW.
//   Clk, Rst        : clock, async active-low reset
//   Req, WE, Addr   : request valid, write select, byte address
//   WData, ByteEn   : write data and lane enables
//   Busy            : transaction in flight (through the Ack cycle)
//   Ack, Err        : completion pulse, rejection flag
//   RData           : read data, valid in a read's Ack cycle, then held
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned AW          = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Req,
   input  logic        WE,
   input  logic [31:0] Addr,
   input  logic [31:0] WData,
   input  logic [3:0]  ByteEn,
   output logic        Busy,
   output logic        Ack,
   output logic [31:0] RData,
   output logic        Err
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_t             req_q, req_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             reject_c;
   logic             rd_en_c;
   logic             wr_en_c;

`ifdef MEMRESP_ERR_CHECK_EN
   assign reject_c = (Addr[1:0] != 2'b00) || (Addr[31:2] >= 30'(DEPTH));
`else
   // Address bits outside the word index are intentionally ignored
   logic unused_addr_c;
   assign unused_addr_c = ^{Addr[31:AW+2], Addr[1:0]};
   assign reject_c      = 1'b0;
`endif

   // Next-state, capture and output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (Req) begin
               req_d = '{we: WE, wdata: WData, byte_en: ByteEn};
               idx_d = Addr[AW+1:2];
               cnt_d = CNT_W'(WAIT_CYCLES);
               if (reject_c) begin
                  state_d = ST_ERR;
               end else if (WAIT_CYCLES != 0) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from the state being entered
      busy_d  = (state_d != ST_IDLE);
      ack_d   = (state_d == ST_RESP) || (state_d == ST_ERR);
      err_d   = (state_d == ST_ERR);
      // Read launched on the edge entering RESP so data lands with Ack
      rd_en_c = (state_d == ST_RESP) && !req_d.we;
      // Write commits on the edge ending RESP
      wr_en_c = (state_q == ST_RESP) && req_q.we;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   mem_resp_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (Clk),
      .rst_n   (Rst),
      .rd_en   (rd_en_c),
      .rd_idx  (idx_d),
      .wr_en   (wr_en_c),
      .wr_idx  (idx_q),
      .wdata   (req_q.wdata),
      .byte_en (req_q.byte_en),
      .rdata   (RData)
   );

   assign Busy = busy_q;
   assign Ack  = ack_q;
   assign Err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 2, 0, 15) share the
// data inputs but have private Req lines. A transaction-level model tracks
// cycles remaining per instance and is compared on every falling edge;
// directed sequences add literal latency/data expectations.
module tb_mem_responder;

   localparam int unsigned WC [3] = '{2, 0, 15};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_i [3];
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  be_i;
   logic        busy_w [3];
   logic        ack_w  [3];
   logic        err_w  [3];
   logic [31:0] rdata_w [3];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(WC[0])) u_dut0 (
      .Clk(clk), .Rst(rst), .Req(req_i[0]), .WE(we_i), .Addr(addr_i),
      .WData(wdata_i), .ByteEn(be_i), .Busy(busy_w[0]), .Ack(ack_w[0]),
      .RData(rdata_w[0]), .Err(err_w[0]));

   mem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(WC[1])) u_dut1 (
      .Clk(clk), .Rst(rst), .Req(req_i[1]), .WE(we_i), .Addr(addr_i),
      .WData(wdata_i), .ByteEn(be_i), .Busy(busy_w[1]), .Ack(ack_w[1]),
      .RData(rdata_w[1]), .Err(err_w[1]));

   mem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(WC[2])) u_dut2 (
      .Clk(clk), .Rst(rst), .Req(req_i[2]), .WE(we_i), .Addr(addr_i),
      .WData(wdata_i), .ByteEn(be_i), .Busy(busy_w[2]), .Ack(ack_w[2]),
      .RData(rdata_w[2]), .Err(err_w[2]));

   // Model: rem = cycles left in the current transaction (1 = Ack cycle)
   int          rem    [3];
   logic        m_we   [3];
   logic        m_err  [3];
   int unsigned m_idx  [3];
   logic [31:0] m_wd   [3];
   logic [3:0]  m_be   [3];
   logic [31:0] exp_rd [3];
   logic [31:0] mem_m  [3][1024];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            rem[k]    = 0;
            exp_rd[k] = 32'h0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (rem[k] == 1) begin
               if (m_we[k] && !m_err[k]) begin
                  for (int b = 0; b < 4; b++) begin
                     if (m_be[k][b]) mem_m[k][m_idx[k]][8*b +: 8] = m_wd[k][8*b +: 8];
                  end
               end
               rem[k] = 0;
            end else if (rem[k] > 1) begin
               rem[k] = rem[k] - 1;
            end else if (req_i[k]) begin
               m_we[k]  = we_i;
               m_idx[k] = int'((addr_i >> 2) % 32'd1024);
               m_wd[k]  = wdata_i;
               m_be[k]  = be_i;
`ifdef MEMRESP_ERR_CHECK_EN
               m_err[k] = (addr_i % 32'd4 != 0) || ((addr_i >> 2) >= 32'd1024);
`else
               m_err[k] = 1'b0;
`endif
               rem[k]   = m_err[k] ? 1 : int'(WC[k]) + 1;
            end
            if (rem[k] == 1 && !m_we[k] && !m_err[k]) exp_rd[k] = mem_m[k][m_idx[k]];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("busy%0d", k),  32'(busy_w[k]), 32'(rem[k] > 0));
         chk($sformatf("ack%0d", k),   32'(ack_w[k]),  32'(rem[k] == 1));
         chk($sformatf("err%0d", k),   32'(err_w[k]),  32'(rem[k] == 1 && m_err[k]));
         chk($sformatf("rdata%0d", k), rdata_w[k],     exp_rd[k]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request on instance k; checks accept-to-Ack latency and Busy length
   task automatic xact(input int k, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int exp_lat, input string tag);
      int lat;
      int busy_n;
      we_i = we; addr_i = a; wdata_i = wd; be_i = be;
      req_i[k] = 1'b1;
      step();
      req_i[k] = 1'b0;
      lat = 0;
      busy_n = 0;
      while (!ack_w[k] && lat < 40) begin
         if (busy_w[k]) busy_n++;
         step();
         lat++;
      end
      if (busy_w[k]) busy_n++;
      chk({tag, "_lat"},  32'(lat),    32'(exp_lat));
      chk({tag, "_busy"}, 32'(busy_n), 32'(exp_lat + 1));
      step();
   endtask

   initial begin
      int acks;
      req_i = '{1'b0, 1'b0, 1'b0};
      we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_ack",  32'(ack_w[0]),  32'd0);
      chk("rst_rdata", rdata_w[0],    32'd0);
      rst = 1'b1;
      step(); step();

      // Full write then read, WAIT_CYCLES=2
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 2, "wr10");
      xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, 2, "rd10");
      chk("rd10_data", rdata_w[0], 32'hDEADBEEF);

      // Partial write and empty-enable write
      xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 2, "pwr");
      xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, 2, "prd");
      chk("prd_data", rdata_w[0], 32'hDE22BE44);
      xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 2, "nowr");
      chk("nowr_hold", rdata_w[0], 32'hDE22BE44);
      xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, 2, "nowr_rd");
      chk("nowr_data", rdata_w[0], 32'hDE22BE44);

`ifdef MEMRESP_ERR_CHECK_EN
      xact(0, 1'b1, 32'h12, 32'h55555555, 4'b1111, 0, "err12");
      xact(0, 1'b0, 32'h1000, 32'h0, 4'b1111, 0, "err1000");
      chk("err_hold", rdata_w[0], 32'hDE22BE44);
      xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, 2, "err_rd");
      chk("err_mem", rdata_w[0], 32'hDE22BE44);
`else
      xact(0, 1'b1, 32'h1012, 32'hCAFEF00D, 4'b1111, 2, "wrap_wr");
      xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, 2, "wrap_rd");
      chk("wrap_data", rdata_w[0], 32'hCAFEF00D);
      xact(0, 1'b0, 32'h1012, 32'h0, 4'b0000, 2, "wrap_rd2");
      chk("wrap_data2", rdata_w[0], 32'hCAFEF00D);
`endif

      // Req held through Busy: only one Ack
      we_i = 1'b0; addr_i = 32'h10; req_i[0] = 1'b1;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (ack_w[0]) acks++;
      end
      req_i[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (ack_w[0]) acks++;
      end
      chk("held_acks", 32'(acks), 32'd1);

      // Back-to-back with Req held, WAIT_CYCLES=0, alternating write/read
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         we_i = (i % 2 == 0);
         addr_i = 32'h40;
         wdata_i = 32'hA0000000 + 32'(i);
         be_i = 4'b1111;
         req_i[1] = 1'b1;
         step();
         if (ack_w[1]) acks++;
         step();
         if (ack_w[1]) acks++;
      end
      req_i[1] = 1'b0;
      chk("b2b_acks", 32'(acks), 32'd8);
      chk("b2b_data", rdata_w[1], 32'hA0000006);
      step();

      // Reset during WAIT of a write: aborted, old contents kept
      xact(0, 1'b1, 32'h20, 32'h12345678, 4'b1111, 2, "wr20");
      we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'hFFFF0000; be_i = 4'b1111;
      req_i[0] = 1'b1;
      step();
      req_i[0] = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("abort_busy",  32'(busy_w[0]), 32'd0);
      chk("abort_ack",   32'(ack_w[0]),  32'd0);
      chk("abort_rdata", rdata_w[0],     32'd0);
      #1 rst = 1'b1;
      step(); step(); step();
      xact(0, 1'b0, 32'h20, 32'h0, 4'b0000, 2, "rd20");
      chk("rd20_data", rdata_w[0], 32'h12345678);

      // Maximum wait states
      xact(2, 1'b1, 32'h30, 32'h0BADCAFE, 4'b1111, 15, "w15_wr");
      xact(2, 1'b0, 32'h30, 32'h0, 4'b0000, 15, "w15_rd");
      chk("w15_data", rdata_w[2], 32'h0BADCAFE);

      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Handshaked data-memory responder: the target end of the CPU's load/store interface.
- Accepts one request at a time (read or byte-enabled write) and inserts a configurable number of wait states.
- Completes each request with a single-cycle Ack carrying read data or an error flag.
- Replaces the zero-latency data memory when the datapath moves to a stalling, multi-cycle memory interface.

Parameters:
- DEPTH, 1024, number of 32-bit words stored.
- AW, 10, word-index width; must satisfy 2^AW >= DEPTH.
- WAIT_CYCLES, 2, wait states between acceptance and response (0..15).

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Rst  input  1  reset, asynchronous, active-low (Rst=0 resets).
- Req  input  1  request valid; sampled only in IDLE.
- WE  input  1  1=write, 0=read; sampled together with Req.
- Addr  input  32  byte address; word index = Addr[AW+1:2].
- WData  input  32  write data; sampled together with Req.
- ByteEn  input  4  write byte lanes; bit i enables WData[8i+7:8i].
- Busy  output  1  high from the cycle after acceptance through the Ack cycle.
- Ack  output  1  one-cycle completion pulse.
- RData  output  32  read data; valid in the Ack cycle of a read.
- Err  output  1  high only in the Ack cycle of a rejected request.

Behaviour:
- Reset (Rst=0, asynchronous):
  - State=IDLE; Busy=0, Ack=0, Err=0, RData=0; wait counter=0.
  - Array contents are not reset.
  - Reset mid-transaction aborts it: no write occurs and no Ack is issued.
- States: IDLE, WAIT, RESP, ERR.
- IDLE:
  - If Req=1, capture WE, word index, WData and ByteEn; load counter=WAIT_CYCLES.
  - Next state: ERR if the request fails the check (see Optional Feature); else WAIT if WAIT_CYCLES>0; else RESP.
  - Req=0: remain in IDLE.
- WAIT: decrement counter each cycle; move to RESP when the counter reaches 1.
- RESP (one cycle):
  - Ack=1, Err=0.
  - Write: lanes with ByteEn=1 updated at the clock edge ending RESP; ByteEn=0000 is a legal no-op that still Acks.
  - Read: RData = full stored word (ByteEn ignored).
  - Next state: IDLE.
- ERR (one cycle): Ack=1, Err=1, array untouched, RData unchanged; next state IDLE.
- Latency, Req accepted at edge N:
  - Ack asserts in cycle N+WAIT_CYCLES+1 (WAIT_CYCLES=0 gives Ack in the next cycle).
  - ERR responses always take exactly 1 cycle.
- Busy: asserted in WAIT/RESP/ERR, deasserted in IDLE.
  - Req while Busy=1 is ignored; it is not queued.
  - Req held high through the Ack cycle is accepted again in the following IDLE cycle (back-to-back rate: one request per WAIT_CYCLES+2 cycles).
- RData holds its last read value across writes, errors and idle cycles.
- A read of a word written by the immediately preceding transaction returns the new data.

Optional Feature:
- Macro MEMRESP_ERR_CHECK_EN.
- Defined: a request is rejected (ERR path) if Addr[1:0]!=00 or Addr[31:2] >= DEPTH.
- Undefined: no check; Addr[1:0] and bits above AW+1 are ignored, so the index wraps modulo 2^AW (DEPTH must be a power of two). Err is tied to 0 and the ERR state is unreachable.

Decomposition:
- Shared package mem_resp_pkg:
  - State encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2, ERR=2'd3).
  - WORD_BYTES=4.
  - Counter width CNT_W=4.
- One sub-module: mem_resp_array.
  - Synchronous DEPTH x 32 storage with per-byte write enable.
  - Registered read port enabled only on the RESP read cycle.
  - The FSM and handshake logic stay in mem_responder.

Test Plan:
- Reset release, WAIT_CYCLES=2: Write Addr=0x10, WData=0xDEADBEEF, ByteEn=1111 -> Busy high 3 cycles, Ack in cycle N+3; then read Addr=0x10 -> RData=0xDEADBEEF with Ack at N+3.
- Partial write: word 0x10 holds 0xDEADBEEF; write ByteEn=0101, WData=0x11223344 -> read returns 0xDE22BE44. Write with ByteEn=0000 -> Ack, word unchanged.
- MEMRESP_ERR_CHECK_EN defined: Req at Addr=0x12 and at Addr=0x1000 (DEPTH=1024) -> Ack+Err next cycle, memory unchanged, RData holds its previous value. Undefined: Addr=0x1012 reads/writes word 4.
- Req held high continuously, WAIT_CYCLES=0, alternating write/read -> one Ack every 2 cycles; Req during Busy produces no extra Ack.
- Rst pulsed low in the WAIT cycle of a write to 0x20 -> outputs zero immediately, no Ack; a later read of 0x20 returns its old contents.
- WAIT_CYCLES=15 read -> Ack exactly 16 cycles after acceptance, Busy high for exactly those 16 cycles.
